// File: rtl/chip8_pkg.sv
// Shared definitions for the CHIP-8 program loader.
// Contents: program memory base address, maximum payload size, frame sync
// byte, loader state enum and a helper that says which states are mid-frame.
package chip8_pkg;

  localparam int unsigned ADDR_W         = 12;
  localparam int unsigned LEN_W          = 16;
  localparam logic [ADDR_W-1:0] PROG_BASE_ADDR = 12'h200;
  localparam int unsigned PROG_MAX_BYTES = 3584;
  localparam logic [7:0]  LOAD_SYNC_BYTE = 8'hC8;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LEN_H,
    LD_LEN_L,
    LD_DATA,
    LD_CSUM,
    LD_DONE,
    LD_ERR
  } loader_state_t;

  // True while a frame is being parsed (busy, inter-byte timeout armed).
  function automatic logic ld_in_frame(loader_state_t s);
    return (s == LD_LEN_H) || (s == LD_LEN_L) || (s == LD_DATA) || (s == LD_CSUM);
  endfunction

endpackage

// File: rtl/chip8_loader_timer.sv
// Inter-byte timeout counter for the program loader.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   arm         count only while high; cleared while low
//   kick        a byte arrived this cycle; clears the count
//   expired     registered; high while TIMEOUT_CYCLES idle clocks have
//               accumulated since the last kick
module loader_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arm,
  input  logic kick,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q, expired_d;

  // Count idle cycles, saturating at the limit.
  always_comb begin
    cnt_d     = cnt_q;
    expired_d = 1'b0;
    if (!arm || kick) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    expired_d = arm && (cnt_d == LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/chip8_loader.sv
// CHIP-8 program loader: parses a framed image from the UART byte stream
// (SYNC 0xC8, LEN_H, LEN_L, payload, optional CSUM) and writes the payload
// into program memory from PROG_BASE upwards, holding the interpreter off
// until a complete valid frame has been loaded.
// Optional feature: define CHIP8_LOAD_CSUM_EN to require a trailing 8-bit
// additive checksum byte.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rx_i, rx_i_v        received byte and its single-cycle valid strobe
//   we, waddr, d        program memory write port (registered)
//   busy                frame being parsed
//   run                 high after a successful load, low from SYNC onward
//   load_done, load_err one-cycle completion / error pulses
module chip8_loader
  import chip8_pkg::*;
#(
  parameter int unsigned        TIMEOUT_CYCLES = 1_000_000,
  parameter logic [ADDR_W-1:0]  PROG_BASE      = PROG_BASE_ADDR,
  parameter int unsigned        PROG_MAX       = PROG_MAX_BYTES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_i,
  input  logic              rx_i_v,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [7:0]        d,
  output logic              busy,
  output logic              run,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [LEN_W-1:0] PROG_MAX_L = LEN_W'(PROG_MAX);

  loader_state_t     state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  len_c;
`ifdef CHIP8_LOAD_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        d_q, d_d;
  logic              busy_q, busy_d;
  logic              run_q, run_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;

  logic              arm_c;
  logic              expired;

  assign len_c = {len_hi_q, rx_i};
  assign arm_c = ld_in_frame(state_q);

  loader_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .arm    (arm_c),
    .kick   (rx_i_v),
    .expired(expired)
  );

  // Frame parser; a byte arriving on the timeout-hit cycle takes priority.
  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    idx_d    = idx_q;
`ifdef CHIP8_LOAD_CSUM_EN
    csum_d   = csum_q;
`endif
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    d_d      = d_q;
    run_d    = run_q;

    case (state_q)
      LD_IDLE: begin
        if (rx_i_v && (rx_i == LOAD_SYNC_BYTE)) begin
          state_d = LD_LEN_H;
          run_d   = 1'b0;
        end
      end
      LD_LEN_H: begin
        if (rx_i_v) begin
          len_hi_d = rx_i;
          state_d  = LD_LEN_L;
        end else if (expired) begin
          state_d = LD_ERR;
        end
      end
      LD_LEN_L: begin
        if (rx_i_v) begin
          if ((len_c == '0) || (len_c > PROG_MAX_L)) begin
            state_d = LD_ERR;
          end else begin
            len_d   = len_c;
            idx_d   = '0;
`ifdef CHIP8_LOAD_CSUM_EN
            csum_d  = '0;
`endif
            state_d = LD_DATA;
          end
        end else if (expired) begin
          state_d = LD_ERR;
        end
      end
      LD_DATA: begin
        if (rx_i_v) begin
          we_d    = 1'b1;
          waddr_d = PROG_BASE + ADDR_W'(idx_q);
          d_d     = rx_i;
          idx_d   = idx_q + LEN_W'(1);
`ifdef CHIP8_LOAD_CSUM_EN
          csum_d  = csum_q + rx_i;
          if (idx_q == (len_q - LEN_W'(1))) state_d = LD_CSUM;
`else
          if (idx_q == (len_q - LEN_W'(1))) state_d = LD_DONE;
`endif
        end else if (expired) begin
          state_d = LD_ERR;
        end
      end
      LD_CSUM: begin
`ifdef CHIP8_LOAD_CSUM_EN
        if (rx_i_v) begin
          state_d = (rx_i == csum_q) ? LD_DONE : LD_ERR;
        end else if (expired) begin
          state_d = LD_ERR;
        end
`else
        state_d = LD_ERR;
`endif
      end
      LD_DONE: state_d = LD_IDLE;
      LD_ERR:  state_d = LD_IDLE;
      default: state_d = LD_IDLE;
    endcase

    if (state_d == LD_DONE) run_d = 1'b1;
    busy_d      = ld_in_frame(state_d);
    load_done_d = (state_d == LD_DONE);
    load_err_d  = (state_d == LD_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LD_IDLE;
      len_hi_q    <= '0;
      len_q       <= '0;
      idx_q       <= '0;
`ifdef CHIP8_LOAD_CSUM_EN
      csum_q      <= '0;
`endif
      we_q        <= 1'b0;
      waddr_q     <= PROG_BASE;
      d_q         <= '0;
      busy_q      <= 1'b0;
      run_q       <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_hi_q    <= len_hi_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
`ifdef CHIP8_LOAD_CSUM_EN
      csum_q      <= csum_d;
`endif
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      d_q         <= d_d;
      busy_q      <= busy_d;
      run_q       <= run_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  assign we        = we_q;
  assign waddr     = waddr_q;
  assign d         = d_q;
  assign busy      = busy_q;
  assign run       = run_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_chip8_loader.sv
// Bench for chip8_loader: directed frames plus randomized traffic, checked
// every cycle against a byte-stream model of the framing rules.
module tb_chip8_loader;

  localparam int unsigned T = 40;
`ifdef CHIP8_LOAD_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_i = 8'h00;
  logic        rx_i_v = 1'b0;
  logic        we;
  logic [11:0] waddr;
  logic [7:0]  d;
  logic        busy, run, load_done, load_err;

  always #5 clk = ~clk;

  chip8_loader #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_i), .rx_i_v(rx_i_v),
    .we(we), .waddr(waddr), .d(d), .busy(busy), .run(run),
    .load_done(load_done), .load_err(load_err)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: position within the frame, idle-cycle count, sum.
  bit          m_in = 0, m_cool = 0;
  int          m_pos = 0, m_len = 0, m_idle = 0;
  logic [7:0]  m_hi = 0, m_sum = 0;
  logic        e_we = 0, e_busy = 0, e_run = 0, e_done = 0, e_err = 0;
  logic [11:0] e_waddr = 12'h200;
  logic [7:0]  e_d = 0;

  function automatic void m_end(bit ok);
    m_in   = 0;
    m_cool = 1;
    if (ok) begin e_done = 1; e_run = 1; end
    else    e_err = 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_in = 0; m_cool = 0; m_pos = 0; m_idle = 0;
      e_we = 0; e_busy = 0; e_run = 0; e_done = 0; e_err = 0;
      e_waddr = 12'h200; e_d = 0;
    end else begin
      e_we = 0; e_done = 0; e_err = 0;
      if (m_cool) begin
        m_cool = 0;
      end else if (!m_in) begin
        if (rx_i_v && rx_i == 8'hC8) begin
          m_in = 1; m_pos = 0; m_idle = 0; m_sum = 0; e_run = 0;
        end
      end else if (rx_i_v) begin
        m_idle = 0;
        if (m_pos == 0) m_hi = rx_i;
        else if (m_pos == 1) begin
          m_len = int'({m_hi, rx_i});
          if (m_len == 0 || m_len > 3584) m_end(0);
        end else if (m_pos - 2 < m_len) begin
          e_we = 1;
          e_waddr = 12'(32'h200 + m_pos - 2);
          e_d = rx_i;
          m_sum = m_sum + rx_i;
          if (m_pos - 2 == m_len - 1 && !CSUM) m_end(1);
        end else begin
          m_end(rx_i == m_sum);
        end
        m_pos++;
      end else begin
        m_idle++;
        if (m_idle > T) m_end(0);
      end
      e_busy = m_in;
    end
  end

  // Cycle compare of every output against the model.
  always @(negedge clk) begin
    vectors++;
    if ({we, waddr, d, busy, run, load_done, load_err} !==
        {e_we, e_waddr, e_d, e_busy, e_run, e_done, e_err}) begin
      miscompares++;
      $display("FAIL cycle t=%0t got we=%b waddr=%h d=%h busy=%b run=%b done=%b err=%b exp we=%b waddr=%h d=%h busy=%b run=%b done=%b err=%b",
               $time, we, waddr, d, busy, run, load_done, load_err,
               e_we, e_waddr, e_d, e_busy, e_run, e_done, e_err);
    end
  end

  // Memory image and event counts as seen on the DUT ports.
  logic [7:0] mem [0:4095];
  int n_w = 0, n_done = 0, n_err = 0;
  int s_w, s_d, s_e;

  always @(posedge clk) begin
    if (rst_n) begin
      if (we) begin mem[waddr] = d; n_w++; end
      if (load_done) n_done++;
      if (load_err) n_err++;
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  task automatic idle(input int n);
    rx_i_v = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rx_i = b;
    rx_i_v = 1'b1;
    @(negedge clk);
    rx_i_v = 1'b0;
  endtask

  task automatic snap();
    s_w = n_w; s_d = n_done; s_e = n_err;
  endtask

  task automatic deltas(input string nm, input int w, input int dn, input int er);
    chk({nm, "_writes"}, n_w - s_w, w);
    chk({nm, "_done"}, n_done - s_d, dn);
    chk({nm, "_err"}, n_err - s_e, er);
  endtask

  task automatic gap_rand();
    int r;
    r = $urandom_range(0, 39);
    if (r < 22)      idle(0);
    else if (r < 34) idle($urandom_range(1, 3));
    else if (r < 37) idle(T);
    else if (r < 39) idle(T + 1);
    else             idle(T + 2);
  endtask

  task automatic rand_frame();
    int len;
    logic [7:0] b, sum;
    if ($urandom_range(0, 3) == 0) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hC8) b = 8'h00;
      send(b);
    end
    case ($urandom_range(0, 9))
      0:       len = 0;
      1:       len = 16'hFFFF;
      default: len = $urandom_range(1, 12);
    endcase
    send(8'hC8);
    gap_rand(); send(8'(len >> 8));
    gap_rand(); send(8'(len));
    if (len >= 1 && len <= 12) begin
      sum = 0;
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom_range(0, 255));
        sum = sum + b;
        gap_rand(); send(b);
      end
      if (CSUM) begin
        gap_rand();
        send(($urandom_range(0, 4) == 0) ? sum ^ 8'h01 : sum);
      end
    end
    idle($urandom_range(0, 3));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_waddr", int'(waddr), 'h200);
    chk("rst_run", int'(run), 0);
    chk("rst_busy", int'(busy), 0);

    // Basic 3-byte load.
    snap();
    send(8'hC8); send(8'h00); send(8'h03);
    send(8'h11); send(8'h22); send(8'h33);
    if (CSUM) send(8'h66);
    idle(3);
    deltas("f1", 3, 1, 0);
    chk("f1_m200", int'(mem[12'h200]), 'h11);
    chk("f1_m201", int'(mem[12'h201]), 'h22);
    chk("f1_m202", int'(mem[12'h202]), 'h33);
    chk("f1_run", int'(run), 1);

    // Wrong checksum (or plain success without checksum).
    snap();
    send(8'hC8); send(8'h00); send(8'h02); send(8'hAA); send(8'hBB);
    if (CSUM) send(8'h00);
    idle(3);
    if (CSUM) begin
      deltas("badsum", 2, 0, 1);
      chk("badsum_run", int'(run), 0);
    end else begin
      deltas("nosum", 2, 1, 0);
    end

    // Length bounds.
    snap();
    send(8'hC8); send(8'h00); send(8'h00); idle(3);
    deltas("len0", 0, 0, 1);
    chk("len0_run", int'(run), 0);
    snap();
    send(8'hC8); send(8'h0E); send(8'h01); idle(3);
    deltas("len3585", 0, 0, 1);
    snap();
    send(8'hC8); send(8'h0E); send(8'h00); idle(3);
    deltas("len3584", 0, 0, 0);
    chk("len3584_busy", int'(busy), 1);
    idle(T);

    // Timeout mid-payload, then recovery.
    snap();
    send(8'hC8); send(8'h00); send(8'h04); send(8'h01); send(8'h02);
    idle(T);
    deltas("to_pre", 2, 0, 0);
    idle(3);
    deltas("to", 2, 0, 1);
    snap();
    send(8'hC8); send(8'h00); send(8'h01); send(8'h5A);
    if (CSUM) send(8'h5A);
    idle(3);
    deltas("to_rec", 1, 1, 0);
    chk("to_rec_m200", int'(mem[12'h200]), 'h5A);

    // Byte arriving on the timeout-hit cycle is accepted.
    snap();
    send(8'hC8); send(8'h00); send(8'h01); idle(T); send(8'h7E);
    if (CSUM) begin idle(T); send(8'h7E); end
    idle(3);
    deltas("hit", 1, 1, 0);

    // Sync-valued payload bytes.
    snap();
    send(8'hC8); send(8'h00); send(8'h02); send(8'hC8); send(8'hC8);
    if (CSUM) send(8'h90);
    idle(3);
    deltas("syncdata", 2, 1, 0);
    chk("syncdata_m200", int'(mem[12'h200]), 'hC8);
    chk("syncdata_m201", int'(mem[12'h201]), 'hC8);

    // Reset mid-payload, then garbage before a new sync.
    snap();
    send(8'hC8); send(8'h00); send(8'h05); send(8'h01); send(8'h02);
    @(posedge clk); #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_waddr", int'(waddr), 'h200);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    send(8'h11); send(8'h00); send(8'h05); send(8'h22); idle(3);
    deltas("rst_mid", 2, 0, 0);
    chk("rst_mid_run", int'(run), 0);

    // Randomized traffic.
    repeat (150) rand_frame();
    idle(T + 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
